// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the Mini-SRC datapath.
// Steps the T0-T2 fetch, decodes the opcode in T3 and drives the execute
// steps. Memory steps wait on mem_ready with an optional timeout. Halt,
// illegal opcodes and memory timeouts all park the unit in HALT until clear.

module control_sequencer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic        mem_fault
);

    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IMM, C_UNARY, C_MULDIV, C_MOVE,
        C_LD, C_LDI, C_ST, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    // Count value seen on the last tolerated wait cycle; unused when MAX_WAIT is 0.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    state_t            next_state;
    logic [4:0]        op_q;
    logic [4:0]        op_now;
    op_class_t         op_class;
    logic              illegal_q;
    logic              fault_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              wait_expired;
    logic              set_illegal;
    logic              set_fault;
    logic              unused_ir_fields;

    // Register fields are decoded downstream by the select/encode logic.
    assign unused_ir_fields = ^ir[26:0];

    function automatic op_class_t decode(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: decode = C_RALU;
            5'b01100, 5'b01101, 5'b01110:           decode = C_IMM;
            5'b10001, 5'b10010:                     decode = C_UNARY;
            5'b01111, 5'b10000:                     decode = C_MULDIV;
            5'b11000, 5'b11001:                     decode = C_MOVE;
            5'b00000:                               decode = C_LD;
            5'b00001:                               decode = C_LDI;
            5'b00010:                               decode = C_ST;
            5'b11010:                               decode = C_NOP;
            5'b11011:                               decode = C_HALT;
            default:                                decode = C_ILLEGAL;
        endcase
    endfunction

    // Immediate ops reuse the ALU add/and/or encodings.
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            5'b01101: imm_alu = 5'b01010;
            5'b01110: imm_alu = 5'b01011;
            default:  imm_alu = 5'b00011;
        endcase
    endfunction

    // The IR is freshly loaded in T3, so decode it live there and from the latched copy afterwards.
    assign op_now       = (state == ST_T3) ? ir[31:27] : op_q;
    assign op_class     = decode(op_now);
    assign wait_expired = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

    // State, latched opcode, sticky flags and wait counter.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_T0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == ST_T3)
                op_q <= ir[31:27];
            if (set_illegal)
                illegal_q <= 1'b1;
            if (set_fault)
                fault_q <= 1'b1;
            if (in_wait && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Next-state and control decode; everything stays low while clear is held.
    always_comb begin
        next_state  = state;
        in_wait     = 1'b0;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
        PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op    = 5'b00000;
        run       = 1'b0;
        illegal   = 1'b0;
        mem_fault = 1'b0;
        if (!clear) begin
            illegal   = illegal_q;
            mem_fault = fault_q;
            run       = (state != ST_HALT);
            case (state)
                ST_T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                    next_state = ST_T1;
                end
                ST_T1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                    in_wait = 1'b1;
                    if (mem_ready) begin
                        next_state = ST_T2;
                    end else if (wait_expired) begin
                        set_fault  = 1'b1;
                        next_state = ST_HALT;
                    end
                end
                ST_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                    next_state = ST_T3;
                end
                ST_T3: begin
                    next_state = ST_T4;
                    case (op_class)
                        C_RALU, C_IMM: begin
                            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        C_UNARY: begin
                            Grb = 1'b1; Rout = 1'b1; alu_op = op_now; Zlowin = 1'b1;
                        end
                        C_MULDIV: begin
                            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        C_MOVE: begin
                            HIout = (op_now == 5'b11000);
                            LOout = (op_now == 5'b11001);
                            Gra = 1'b1; Rin = 1'b1;
                            next_state = ST_T0;
                        end
                        C_LD, C_LDI, C_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                        end
                        C_NOP: next_state = ST_T0;
                        C_HALT: next_state = ST_HALT;
                        default: begin
                            set_illegal = 1'b1;
                            next_state  = ST_HALT;
                        end
                    endcase
                end
                ST_T4: begin
                    next_state = ST_T5;
                    case (op_class)
                        C_RALU: begin
                            Grc = 1'b1; Rout = 1'b1; alu_op = op_now; Zlowin = 1'b1;
                        end
                        C_IMM: begin
                            Cout = 1'b1; alu_op = imm_alu(op_now); Zlowin = 1'b1;
                        end
                        C_UNARY: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            next_state = ST_T0;
                        end
                        C_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; alu_op = op_now;
                            Zlowin = 1'b1; Zhighin = 1'b1;
                        end
                        default: begin
                            Cout = 1'b1; alu_op = 5'b00011; Zlowin = 1'b1;
                        end
                    endcase
                end
                ST_T5: begin
                    next_state = ST_T6;
                    case (op_class)
                        C_MULDIV: begin
                            Zlowout = 1'b1; LOin = 1'b1;
                        end
                        C_LD, C_ST: begin
                            Zlowout = 1'b1; MARin = 1'b1;
                        end
                        default: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            next_state = ST_T0;
                        end
                    endcase
                end
                ST_T6: begin
                    case (op_class)
                        C_LD: begin
                            Read = 1'b1; MDRin = 1'b1;
                            in_wait = 1'b1;
                            if (mem_ready) begin
                                next_state = ST_T7;
                            end else if (wait_expired) begin
                                set_fault  = 1'b1;
                                next_state = ST_HALT;
                            end
                        end
                        C_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                            next_state = ST_T7;
                        end
                        default: begin
                            Zhighout = 1'b1; HIin = 1'b1;
                            next_state = ST_T0;
                        end
                    endcase
                end
                ST_T7: begin
                    if (op_class == C_ST) begin
                        Write = 1'b1;
                        in_wait = 1'b1;
                        if (mem_ready) begin
                            next_state = ST_T0;
                        end else if (wait_expired) begin
                            set_fault  = 1'b1;
                            next_state = ST_HALT;
                        end
                    end else begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        next_state = ST_T0;
                    end
                end
                default: begin
                    next_state = ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle check of the full control bundle against
// expected words built from independent bit masks. Straight-line programs
// come from a vector table; memory waits, timeout, halt/illegal and clear
// mid-instruction are written out by hand.

module tb_control_sequencer;

    localparam logic [24:0] M_PCOUT    = 25'h1 << 24;
    localparam logic [24:0] M_ZLOWOUT  = 25'h1 << 23;
    localparam logic [24:0] M_ZHIGHOUT = 25'h1 << 22;
    localparam logic [24:0] M_MDROUT   = 25'h1 << 21;
    localparam logic [24:0] M_HIOUT    = 25'h1 << 20;
    localparam logic [24:0] M_LOOUT    = 25'h1 << 19;
    localparam logic [24:0] M_COUT     = 25'h1 << 18;
    localparam logic [24:0] M_PCIN     = 25'h1 << 17;
    localparam logic [24:0] M_INCPC    = 25'h1 << 16;
    localparam logic [24:0] M_MARIN    = 25'h1 << 15;
    localparam logic [24:0] M_MDRIN    = 25'h1 << 14;
    localparam logic [24:0] M_IRIN     = 25'h1 << 13;
    localparam logic [24:0] M_YIN      = 25'h1 << 12;
    localparam logic [24:0] M_ZLOWIN   = 25'h1 << 11;
    localparam logic [24:0] M_ZHIGHIN  = 25'h1 << 10;
    localparam logic [24:0] M_HIIN     = 25'h1 << 9;
    localparam logic [24:0] M_LOIN     = 25'h1 << 8;
    localparam logic [24:0] M_READ     = 25'h1 << 7;
    localparam logic [24:0] M_WRITE    = 25'h1 << 6;
    localparam logic [24:0] M_GRA      = 25'h1 << 5;
    localparam logic [24:0] M_GRB      = 25'h1 << 4;
    localparam logic [24:0] M_GRC      = 25'h1 << 3;
    localparam logic [24:0] M_RIN      = 25'h1 << 2;
    localparam logic [24:0] M_ROUT     = 25'h1 << 1;
    localparam logic [24:0] M_BAOUT    = 25'h1 << 0;

    localparam logic [24:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
    localparam logic [24:0] E_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [24:0] E_T2 = M_MDROUT | M_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_MUL  = 32'h81A00000;
    localparam logic [31:0] IR_ADDI = 32'h60000000;
    localparam logic [31:0] IR_ORI  = 32'h70000000;
    localparam logic [31:0] IR_NEG  = 32'h88000000;
    localparam logic [31:0] IR_MFHI = 32'hC0000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BR   = 32'h98000000;
    localparam logic [31:0] IR_LD   = 32'h00900055;
    localparam logic [31:0] IR_ST   = 32'h10000000;

    typedef struct {
        logic [95:0] nm;
        logic        clr;
        logic [31:0] ir;
        logic        rdy;
        logic [24:0] ctl;
        logic [4:0]  alu;
        logic        run;
        logic        ill;
        logic        flt;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        mem_ready = 1'b0;

    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout;
    logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_op;
    logic run, illegal, mem_fault;
    logic [24:0] act_ctl;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clock = ~clock;

    control_sequencer #(.MAX_WAIT(4), .WAIT_W(8)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
        .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run), .illegal(illegal), .mem_fault(mem_fault)
    );

    assign act_ctl = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
                      PCin, IncPC, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin,
                      Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    function automatic vec_t mk(input logic [95:0] nm, input logic clr, input logic [31:0] i,
                                input logic rdy, input logic [24:0] ctl, input logic [4:0] alu,
                                input logic r, input logic il, input logic fl);
        vec_t v;
        v.nm = nm; v.clr = clr; v.ir = i; v.rdy = rdy; v.ctl = ctl;
        v.alu = alu; v.run = r; v.ill = il; v.flt = fl;
        return v;
    endfunction

    // Vector for a running cycle with no sticky flags.
    function automatic vec_t mkr(input logic [95:0] nm, input logic [31:0] i, input logic rdy,
                                 input logic [24:0] ctl, input logic [4:0] alu);
        return mk(nm, 1'b0, i, rdy, ctl, alu, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic add_fetch(input logic [31:0] i);
        tbl.push_back(mkr("T0", i, 1'b1, E_T0, 5'd0));
        tbl.push_back(mkr("T1", i, 1'b1, E_T1, 5'd0));
        tbl.push_back(mkr("T2", i, 1'b1, E_T2, 5'd0));
    endtask

    // Drive one cycle of inputs just after the falling edge and queue its expectation.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        clear     = v.clr;
        ir        = v.ir;
        mem_ready = v.rdy;
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against the settled outputs.
    task automatic checkOutput();
        vec_t e;
        logic [32:0] act;
        logic [32:0] expv;
        #2;
        check_cnt++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard: actual=empty required=entry");
        end else begin
            e    = exp_q.pop_front();
            act  = {act_ctl, alu_op, run, illegal, mem_fault};
            expv = {e.ctl, e.alu, e.run, e.ill, e.flt};
            if (act !== expv)
                $display("[TB] FAIL %s @%0t: actual=%h required=%h (ctl,alu,run,ill,flt)",
                         e.nm, $time, act, expv);
            else
                pass_cnt++;
        end
    endtask

    task automatic cyc(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        // Straight-line programs: add, mul, addi, neg, mfhi, nop, ori.
        tbl.push_back(mk("rst0", 1'b1, IR_ADD, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("rst1", 1'b1, IR_ADD, 1'b1, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        add_fetch(IR_ADD);
        tbl.push_back(mkr("add_T3", IR_ADD, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0));
        tbl.push_back(mkr("add_T4", IR_ADD, 1'b0, M_GRC | M_ROUT | M_ZLOWIN, 5'b00011));
        tbl.push_back(mkr("add_T5", IR_ADD, 1'b0, M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        add_fetch(IR_MUL);
        tbl.push_back(mkr("mul_T3", IR_MUL, 1'b1, M_GRA | M_ROUT | M_YIN, 5'd0));
        tbl.push_back(mkr("mul_T4", IR_MUL, 1'b1, M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, 5'b10000));
        tbl.push_back(mkr("mul_T5", IR_MUL, 1'b1, M_ZLOWOUT | M_LOIN, 5'd0));
        tbl.push_back(mkr("mul_T6", IR_MUL, 1'b1, M_ZHIGHOUT | M_HIIN, 5'd0));
        add_fetch(IR_ADDI);
        tbl.push_back(mkr("addi_T3", IR_ADDI, 1'b1, M_GRB | M_ROUT | M_YIN, 5'd0));
        tbl.push_back(mkr("addi_T4", IR_ADDI, 1'b1, M_COUT | M_ZLOWIN, 5'b00011));
        tbl.push_back(mkr("addi_T5", IR_ADDI, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        add_fetch(IR_NEG);
        tbl.push_back(mkr("neg_T3", IR_NEG, 1'b1, M_GRB | M_ROUT | M_ZLOWIN, 5'b10001));
        tbl.push_back(mkr("neg_T4", IR_NEG, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        add_fetch(IR_MFHI);
        tbl.push_back(mkr("mfhi_T3", IR_MFHI, 1'b1, M_HIOUT | M_GRA | M_RIN, 5'd0));
        add_fetch(IR_NOP);
        tbl.push_back(mkr("nop_T3", IR_NOP, 1'b1, 25'h0, 5'd0));
        add_fetch(IR_ORI);
        tbl.push_back(mkr("ori_T3", IR_ORI, 1'b1, M_GRB | M_ROUT | M_YIN, 5'd0));
        tbl.push_back(mkr("ori_T4", IR_ORI, 1'b1, M_COUT | M_ZLOWIN, 5'b01011));
        tbl.push_back(mkr("ori_T5", IR_ORI, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0));

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i]);

        // ld with three wait cycles in T1 (ready on the last tolerated count) and two in T6; ir changes after T3.
        cyc(mkr("ld_T0", IR_LD, 1'b0, E_T0, 5'd0));
        for (int i = 0; i < 3; i++)
            cyc(mkr("ld_T1wait", IR_LD, 1'b0, E_T1, 5'd0));
        cyc(mkr("ld_T1rdy", IR_LD, 1'b1, E_T1, 5'd0));
        cyc(mkr("ld_T2", IR_LD, 1'b0, E_T2, 5'd0));
        cyc(mkr("ld_T3", IR_LD, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'd0));
        cyc(mkr("ld_T4", IR_HALT, 1'b1, M_COUT | M_ZLOWIN, 5'b00011));
        cyc(mkr("ld_T5", IR_HALT, 1'b1, M_ZLOWOUT | M_MARIN, 5'd0));
        for (int i = 0; i < 2; i++)
            cyc(mkr("ld_T6wait", IR_HALT, 1'b0, M_READ | M_MDRIN, 5'd0));
        cyc(mkr("ld_T6rdy", IR_HALT, 1'b1, M_READ | M_MDRIN, 5'd0));
        cyc(mkr("ld_T7", IR_HALT, 1'b0, M_MDROUT | M_GRA | M_RIN, 5'd0));

        // Full st; mem_ready low in T6 must not stall it, T7 waits one cycle.
        cyc(mkr("st_T0", IR_ST, 1'b1, E_T0, 5'd0));
        cyc(mkr("st_T1", IR_ST, 1'b1, E_T1, 5'd0));
        cyc(mkr("st_T2", IR_ST, 1'b1, E_T2, 5'd0));
        cyc(mkr("st_T3", IR_ST, 1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0));
        cyc(mkr("st_T4", IR_ST, 1'b1, M_COUT | M_ZLOWIN, 5'b00011));
        cyc(mkr("st_T5", IR_ST, 1'b1, M_ZLOWOUT | M_MARIN, 5'd0));
        cyc(mkr("st_T6", IR_ST, 1'b0, M_GRA | M_ROUT | M_MDRIN, 5'd0));
        cyc(mkr("st_T7wait", IR_ST, 1'b0, M_WRITE, 5'd0));
        cyc(mkr("st_T7rdy", IR_ST, 1'b1, M_WRITE, 5'd0));

        // st aborted by clear in T6; fetch restarts, then a halt instruction.
        cyc(mkr("st2_T0", IR_ST, 1'b1, E_T0, 5'd0));
        cyc(mkr("st2_T1", IR_ST, 1'b1, E_T1, 5'd0));
        cyc(mkr("st2_T2", IR_ST, 1'b1, E_T2, 5'd0));
        cyc(mkr("st2_T3", IR_ST, 1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0));
        cyc(mkr("st2_T4", IR_ST, 1'b1, M_COUT | M_ZLOWIN, 5'b00011));
        cyc(mkr("st2_T5", IR_ST, 1'b1, M_ZLOWOUT | M_MARIN, 5'd0));
        cyc(mk("st2_clr", 1'b1, IR_ST, 1'b1, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        cyc(mkr("after_clr", IR_HALT, 1'b1, E_T0, 5'd0));
        cyc(mkr("halt_T1", IR_HALT, 1'b1, E_T1, 5'd0));
        cyc(mkr("halt_T2", IR_HALT, 1'b1, E_T2, 5'd0));
        cyc(mkr("halt_T3", IR_HALT, 1'b1, 25'h0, 5'd0));
        for (int i = 0; i < 2; i++)
            cyc(mk("halted", 1'b0, IR_ADD, 1'b1, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));

        // Illegal opcode (br) sets the sticky flag and halts.
        cyc(mk("clr_halt", 1'b1, IR_BR, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        cyc(mkr("br_T0", IR_BR, 1'b1, E_T0, 5'd0));
        cyc(mkr("br_T1", IR_BR, 1'b1, E_T1, 5'd0));
        cyc(mkr("br_T2", IR_BR, 1'b1, E_T2, 5'd0));
        cyc(mkr("br_T3", IR_BR, 1'b1, 25'h0, 5'd0));
        for (int i = 0; i < 2; i++)
            cyc(mk("br_halt", 1'b0, IR_ADD, 1'b1, 25'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        cyc(mk("clr_ill", 1'b1, IR_ADD, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));

        // Timeout: four unanswered T1 cycles with MAX_WAIT=4 raise mem_fault.
        cyc(mkr("to_T0", IR_ADD, 1'b0, E_T0, 5'd0));
        for (int i = 0; i < 4; i++)
            cyc(mkr("to_T1wait", IR_ADD, 1'b0, E_T1, 5'd0));
        cyc(mk("to_halt", 1'b0, IR_ADD, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        cyc(mk("to_halt_rdy", 1'b0, IR_ADD, 1'b1, 25'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        cyc(mk("to_halt", 1'b0, IR_ADD, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b1));
        cyc(mk("clr_fault", 1'b1, IR_ADD, 1'b0, 25'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        cyc(mkr("final_T0", IR_ADD, 1'b1, E_T0, 5'd0));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
